// File: rtl/channel_out_pkg.sv
// Shared types and constants for the NeoPixel channel output block.
// Holds the FSM state enum, the phase-timing bundle and phase-length helpers.
package channel_out_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int COLOR_W   = 24;
    localparam int RAM_DEPTH = 256;
    localparam int CNT_W     = 8;
    localparam int LANE_W    = 8;
    localparam int BE_W      = DATA_W / LANE_W;
    localparam int BIT_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SEND_H = 2'd2,
        SEND_L = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] t0h;
        logic [CNT_W-1:0] t0l;
        logic [CNT_W-1:0] t1h;
        logic [CNT_W-1:0] t1l;
    } timing_t;

    // Counter load value for the high phase of a bit; phase lasts value+1 cycles.
    function automatic logic [CNT_W-1:0] high_len(input timing_t t, input logic bit_val);
        return bit_val ? t.t1h : t.t0h;
    endfunction

    function automatic logic [CNT_W-1:0] low_len(input timing_t t, input logic bit_val);
        return bit_val ? t.t1l : t.t0l;
    endfunction

endpackage

// File: rtl/channel_out_if.sv
// LED RAM write bus plus the frame-start strobe that travels with it.
// The master side drives, channel_out consumes through the slave modport.
interface channel_out_if;
    import channel_out_pkg::*;

    logic              ram_wr_en;
    logic              ram_wr_done;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [LANE_W-1:0] ram_wr_data;
    logic [BE_W-1:0]   ram_wr_byte_en;

    modport master (
        output ram_wr_en,
        output ram_wr_done,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_wr_byte_en
    );

    modport slave (
        input ram_wr_en,
        input ram_wr_done,
        input ram_wr_addr,
        input ram_wr_data,
        input ram_wr_byte_en
    );

endinterface

// File: rtl/channel_ram.sv
// 256x32 simple dual-port LED RAM: byte-lane write port, registered read port.
// A read of the address being written in the same cycle returns the old word.
module channel_ram
    import channel_out_pkg::*;
(
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LANE_W-1:0] wr_data_i,
    input  logic [BE_W-1:0]   wr_byte_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset so a reset mid-frame keeps the frame.
    always_ff @(posedge clk_i) begin
        rd_data_q <= mem_q[rd_addr_i];
        if (wr_en_i) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_byte_en_i[k]) begin
                    mem_q[wr_addr_i][LANE_W*k +: LANE_W] <= wr_data_i;
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/channel_out.sv
// NeoPixel single-wire serialiser: walks a linked list of LED words in RAM
// and emits each 24-bit colour MSB first with programmable high/low phases.
//
//   state  | meaning
//   IDLE   | output low, waiting for a frame-start request
//   READ   | word 0 available from RAM, load shifter and link
//   SEND_H | high phase of the current bit
//   SEND_L | low phase of the current bit, then next bit or next word
module channel_out
    import channel_out_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CNT_W-1:0]    reg_t0h_time_i,
    input  logic [CNT_W-1:0]    reg_t0l_time_i,
    input  logic [CNT_W-1:0]    reg_t1h_time_i,
    input  logic [CNT_W-1:0]    reg_t1l_time_i,
    channel_out_if.slave        bus,
    output logic                bit_code_o
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [COLOR_W-1:0]     shift_q, shift_d;
    logic [ADDR_W-1:0]      next_addr_q, next_addr_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   bit_code_q, bit_code_d;

    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    timing_t                timing;
    logic                   cur_bit;
    logic                   next_bit;
    logic                   cnt_tc;
    logic                   last_bit;
    logic                   load_word;

    assign timing = '{
        t0h: reg_t0h_time_i,
        t0l: reg_t0l_time_i,
        t1h: reg_t1h_time_i,
        t1l: reg_t1l_time_i
    };

    assign cur_bit  = shift_q[COLOR_W-1];
    assign next_bit = shift_q[COLOR_W-2];
    assign cnt_tc   = (cnt_q == '0);
    assign last_bit = (bit_idx_q == '0);

    channel_ram u_ram (
        .clk_i        (clk_i),
        .wr_en_i      (bus.ram_wr_en),
        .wr_addr_i    (bus.ram_wr_addr),
        .wr_data_i    (bus.ram_wr_data),
        .wr_byte_en_i (bus.ram_wr_byte_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data)
    );

    // The read port tracks the link register for the whole word, so the
    // following word is already registered by the last low cycle of bit 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        next_addr_d = next_addr_q;
        bit_idx_d   = bit_idx_q;
        load_word   = 1'b0;
        rd_addr     = next_addr_q;

        case (state_q)
            IDLE: begin
                rd_addr = '0;
                if (bus.ram_wr_done) begin
                    next_addr_d = '0;
                    state_d     = READ;
                end
            end

            READ: begin
                load_word = 1'b1;
            end

            SEND_H: begin
                if (cnt_tc) begin
                    cnt_d   = low_len(timing, cur_bit);
                    state_d = SEND_L;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SEND_L: begin
                if (!cnt_tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!last_bit) begin
                    shift_d   = {shift_q[COLOR_W-2:0], 1'b0};
                    bit_idx_d = bit_idx_q - BIT_IDX_W'(1);
                    cnt_d     = high_len(timing, next_bit);
                    state_d   = SEND_H;
                end else if (next_addr_q == '0) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = IDLE;
                end else begin
                    load_word = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_word) begin
            shift_d     = rd_data[COLOR_W-1:0];
            next_addr_d = rd_data[DATA_W-1:COLOR_W];
            bit_idx_d   = BIT_IDX_W'(COLOR_W - 1);
            cnt_d       = high_len(timing, rd_data[COLOR_W-1]);
            state_d     = SEND_H;
        end

        bit_code_d = (state_q == SEND_H);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            next_addr_q <= '0;
            bit_idx_q   <= '0;
            bit_code_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            next_addr_q <= next_addr_d;
            bit_idx_q   <= bit_idx_d;
            bit_code_q  <= bit_code_d;
        end
    end

    assign bit_code_o = bit_code_q;

endmodule

// File: tb/tb_channel_out.sv
// Bench for channel_out: a waveform-queue model predicts the serial output
// every cycle, with directed frames and literal expectations around it.
`timescale 1ns/1ps
module tb_channel_out;

    localparam int HOLD_CYCLES     = 65536;
    localparam int WATCHDOG_CYCLES = 95000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] t0h = 8'd0;
    logic [7:0] t0l = 8'd1;
    logic [7:0] t1h = 8'd1;
    logic [7:0] t1l = 8'd0;
    logic       bit_code_o;

    channel_out_if bus ();

    channel_out dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reg_t0h_time_i (t0h),
        .reg_t0l_time_i (t0l),
        .reg_t1h_time_i (t1h),
        .reg_t1l_time_i (t1l),
        .bus            (bus),
        .bit_code_o     (bit_code_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Model: the expected output is a queue of per-cycle levels; each LED word
    // expands into (tXh+1) ones and (tXl+1) zeros per bit, MSB first.
    logic [31:0] m_mem [256];
    bit          m_q [$];
    bit          m_active = 1'b0;
    logic [7:0]  m_addr   = 8'd0;
    logic        m_exp    = 1'b0;
    bit          chk_en   = 1'b0;

    function automatic void push_phase(input bit level, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) m_q.push_back(level);
    endfunction

    function automatic void append_word(input logic [31:0] w);
        for (int i = 23; i >= 0; i--) begin
            push_phase(1'b1, w[i] ? t1h : t0h);
            push_phase(1'b0, w[i] ? t1l : t0l);
        end
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_q.delete();
            m_active = 1'b0;
            m_exp    = 1'b0;
            chk_en   = 1'b1;
        end else if (!m_active && m_q.size() == 0) begin
            m_exp = 1'b0;
            if (bus.ram_wr_done) begin
                m_active = 1'b1;
                m_addr   = 8'd0;
                m_q.push_back(1'b0);
            end
        end else begin
            if (m_active && m_q.size() < 2) begin
                append_word(m_mem[m_addr]);
                m_addr   = m_mem[m_addr][31:24];
                m_active = (m_addr != 8'd0);
            end
            m_exp = m_q.pop_front();
        end
        if (bus.ram_wr_en) begin
            for (int k = 0; k < 4; k++)
                if (bus.ram_wr_byte_en[k]) m_mem[bus.ram_wr_addr][8*k +: 8] = bus.ram_wr_data;
        end
    end

    int run_len = 0;
    int max_run = 0;

    always @(negedge clk_i) begin
        if (chk_en) check("wave", bit_code_o, m_exp);
        if (bit_code_o === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [3:0] be);
        bus.ram_wr_en      = 1'b1;
        bus.ram_wr_addr    = a;
        bus.ram_wr_data    = d;
        bus.ram_wr_byte_en = be;
        tick(1);
        bus.ram_wr_en      = 1'b0;
    endtask

    task automatic wr_word(input logic [7:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) wr(a, w[8*k +: 8], 4'(1 << k));
    endtask

    task automatic pulse_done();
        bus.ram_wr_done = 1'b1;
        tick(1);
        bus.ram_wr_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (m_active || m_q.size() != 0) ? 32'd1 : 32'd0, 32'd0);
        tick(2);
        check({name, "_out_low"}, bit_code_o, 1'b0);
    endtask

    initial begin
        int         n_hi;
        int         last_hi;
        logic [23:0] colour;

        bus.ram_wr_en      = 1'b0;
        bus.ram_wr_done    = 1'b0;
        bus.ram_wr_addr    = 8'd0;
        bus.ram_wr_data    = 8'd0;
        bus.ram_wr_byte_en = 4'd0;

        tick(3);
        check("reset_out", bit_code_o, 1'b0);
        rst_i = 1'b0;

        wr_word(8'd0, 32'h01000000);
        wr_word(8'd1, 32'h02AAAAAA);
        wr_word(8'd2, 32'h03CCCCCC);
        wr_word(8'd3, 32'h00FFFFFF);
        check("model_word1", m_mem[1], 32'h02AAAAAA);

        // Four-word frame: 96 bits, 288 contiguous cycles, 144 of them high.
        pulse_done();
        check("lat_idle", bit_code_o, 1'b0);
        tick(1);
        check("lat_read", bit_code_o, 1'b0);
        tick(1);
        check("first_rise", bit_code_o, 1'b1);
        n_hi    = 1;
        last_hi = 0;
        for (int i = 1; i < 400; i++) begin
            tick(1);
            if (bit_code_o === 1'b1) begin
                n_hi++;
                last_hi = i;
            end
        end
        check("frame_high_cycles", n_hi, 144);
        check("frame_last_high", last_hi, 286);
        wait_idle("frame1_end", 10);

        // Other timing, and a done request that lands mid-frame.
        t0h = 8'd2; t0l = 8'd3; t1h = 8'd0; t1l = 8'd4;
        pulse_done();
        tick(60);
        pulse_done();
        wait_idle("mid_frame_done", 2000);

        t0h = 8'd0; t0l = 8'd1; t1h = 8'd1; t1l = 8'd0;
        bus.ram_wr_done = 1'b1;
        tick(HOLD_CYCLES);
        bus.ram_wr_done = 1'b0;
        wait_idle("held_done", 1000);

        // Reset while a "0" bit is high, then replay the frame.
        pulse_done();
        tick(101);
        check("pre_reset_high", bit_code_o, 1'b1);
        rst_i = 1'b1;
        tick(1);
        check("reset_abort", bit_code_o, 1'b0);
        rst_i = 1'b0;
        pulse_done();
        wait_idle("replay", 1000);

        // Partial lane write keeps the link byte.
        wr_word(8'd0, 32'h07123456);
        wr(8'd0, 8'h5A, 4'b0111);
        wr_word(8'd7, 32'h00C3C3C3);
        check("lane_mask_model", m_mem[0], 32'h075A5A5A);
        pulse_done();
        tick(1);
        colour = '0;
        for (int b = 0; b < 24; b++) begin
            tick(2);
            colour = {colour[22:0], bit_code_o};
            tick(1);
        end
        check("lane_colour", colour, 24'h5A5A5A);
        wait_idle("lane_frame", 1000);

        pulse_done();
        tick(10);
        wr_word(8'd7, 32'h003C0FF0);
        wait_idle("late_write", 1000);

        // Self-linked word loops until reset; 26 high cycles per 72-cycle word.
        wr_word(8'd7, 32'h07800001);
        pulse_done();
        tick(2000);
        n_hi = 0;
        for (int i = 0; i < 144; i++) begin
            tick(1);
            if (bit_code_o === 1'b1) n_hi++;
        end
        check("loop_highs", n_hi, 52);
        rst_i = 1'b1;
        tick(1);
        check("loop_reset", bit_code_o, 1'b0);
        rst_i = 1'b0;
        tick(2);

        t1h = 8'd255;
        wr_word(8'd0, 32'h00800000);
        pulse_done();
        wait_idle("long_high_frame", 2000);
        check("long_high_run", max_run, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        repeat (WATCHDOG_CYCLES) @(posedge clk_i);
        $display("FAIL watchdog: reached %0d cycles, required finish before that", WATCHDOG_CYCLES);
        $fatal(1, "timeout");
    end

endmodule
